// File: rtl/gpio_mulpop_pkg.sv
// Shared definitions for the gpio_mulpop register block: FSM encoding,
// register offsets relative to BASE, and the status word layout.
package gpio_mulpop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MULT  = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [15:0] OFF_A1    = 16'h0000;
  localparam logic [15:0] OFF_A2    = 16'h0008;
  localparam logic [15:0] OFF_W     = 16'h0010;
  localparam logic [15:0] OFF_L     = 16'h0018;
  localparam logic [15:0] OFF_CTRL  = 16'h0020;
  localparam logic [15:0] OFF_STATE = 16'h0024;

  // Field order gives the read-back layout {err, ready, valid}.
  typedef struct packed {
    logic err;
    logic ready;
    logic valid;
  } status_t;

endpackage

// File: rtl/gpio_mulpop_popcnt.sv
// Combinational population count of a WIDTH-bit vector.
module gpio_mulpop_popcnt #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]             i_vec,
  output logic [$clog2(WIDTH+1)-1:0]   o_cnt
);
  localparam int CW = $clog2(WIDTH+1);

  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < WIDTH; i++) o_cnt = o_cnt + CW'(i_vec[i]);
  end

endmodule

// File: rtl/gpio_mulpop.sv
// Memory-mapped shift-add multiplier with popcount of the result, an op
// counter on gpio_out and an edge-triggered capture register for gpio_in.
module gpio_mulpop
  import gpio_mulpop_pkg::*;
#(
  parameter int          OP_W  = 24,
  parameter int          RES_W = 32,
  parameter logic [15:0] BASE  = 16'h0380
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  input  logic [31:0] gpio_in,
  input  logic        gpio_latch,
  output logic [31:0] gpio_in_s_insp,
  output logic [31:0] gpio_out,
  output logic        irq
);
  localparam int PW = 2 * OP_W;
  localparam int CW = $clog2(RES_W + 1);
  localparam int NW = (OP_W > 1) ? $clog2(OP_W) : 1;

  state_e            r_state, w_state_nxt;
  logic [OP_W-1:0]   r_a1, r_a2, r_mplier;
  logic [PW-1:0]     r_mcand, r_acc;
  logic [NW-1:0]     r_bit;
  logic [RES_W-1:0]  r_w;
  logic [CW-1:0]     r_l, w_pop;
  status_t           r_sts;
  logic [15:0]       r_op_cnt;
  logic              r_irq, r_latch_q;
  logic [31:0]       r_gpio_in_s, r_sdata_out, w_rdata;
  logic              w_wr_a1, w_wr_a2, w_start, w_hi_zero;
  logic              w_unused_ok;

  assign w_wr_a1 = swr && (saddress == BASE + OFF_A1);
  assign w_wr_a2 = swr && (saddress == BASE + OFF_A2);
  assign w_start = swr && (saddress == BASE + OFF_CTRL);
  // Shifting by RES_W yields zero when the product fits the result width.
  assign w_hi_zero = ((r_acc >> RES_W) == '0);
  assign w_unused_ok = ^sdata_in;

  gpio_mulpop_popcnt #(.WIDTH(RES_W)) u_popcnt (
    .i_vec (r_acc[RES_W-1:0]),
    .o_cnt (w_pop)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_state_nxt = ST_MULT;
      ST_MULT:  if (r_bit == NW'(OP_W - 1)) w_state_nxt = ST_COUNT;
      ST_COUNT: w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_a1     <= '0;
      r_a2     <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_bit    <= '0;
      r_w      <= '0;
      r_l      <= '0;
      r_sts    <= '{err: 1'b0, ready: 1'b1, valid: 1'b1};
      r_op_cnt <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_a1) r_a1 <= sdata_in[OP_W-1:0];
      if (w_wr_a2) r_a2 <= sdata_in[OP_W-1:0];
      r_irq <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_start) begin
          r_mcand     <= PW'(r_a1);
          r_mplier    <= r_a2;
          r_acc       <= '0;
          r_bit       <= '0;
          r_sts.ready <= 1'b0;
          r_sts.err   <= 1'b0;
        end
        ST_MULT: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_bit    <= r_bit + 1'b1;
        end
        ST_COUNT: begin
          r_w         <= r_acc[RES_W-1:0];
          r_l         <= w_pop;
          r_sts.valid <= w_hi_zero;
        end
        ST_DONE: begin
          r_sts.ready <= 1'b1;
          r_op_cnt    <= r_op_cnt + 16'd1;
          r_irq       <= 1'b1;
        end
        default: ;
      endcase
      // A start while busy is only flagged; the running operation continues.
      if (w_start && r_state != ST_IDLE) r_sts.err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_latch_q   <= 1'b0;
      r_gpio_in_s <= '0;
    end else begin
      r_latch_q <= gpio_latch;
      if (gpio_latch && !r_latch_q) r_gpio_in_s <= gpio_in;
    end
  end

  always_comb begin
    w_rdata = '0;
    if      (saddress == BASE + OFF_A1)    w_rdata = 32'(r_a1);
    else if (saddress == BASE + OFF_A2)    w_rdata = 32'(r_a2);
    else if (saddress == BASE + OFF_W)     w_rdata = 32'(r_w);
    else if (saddress == BASE + OFF_L)     w_rdata = 32'(r_l);
    else if (saddress == BASE + OFF_CTRL)  w_rdata = 32'(r_sts);
    else if (saddress == BASE + OFF_STATE) w_rdata = 32'(r_state);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)  r_sdata_out <= '0;
    else if (srd)  r_sdata_out <= w_rdata;
  end

  assign sdata_out      = r_sdata_out;
  assign gpio_in_s_insp = r_gpio_in_s;
  assign gpio_out       = {16'h0, r_op_cnt};
  assign irq            = r_irq;

endmodule

// File: tb/tb_gpio_mulpop.sv
// Directed bench for gpio_mulpop: a cycle-level reference model checked every
// cycle, plus register reads against hand-computed values.
module tb_gpio_mulpop;
  localparam int          OP_W = 24;
  localparam logic [15:0] BASE = 16'h0380;
  localparam logic [15:0] A_A1    = BASE + 16'h00;
  localparam logic [15:0] A_A2    = BASE + 16'h08;
  localparam logic [15:0] A_W     = BASE + 16'h10;
  localparam logic [15:0] A_L     = BASE + 16'h18;
  localparam logic [15:0] A_CTRL  = BASE + 16'h20;
  localparam logic [15:0] A_STATE = BASE + 16'h24;

  logic        clk = 1'b0, n_reset = 1'b0;
  logic [15:0] saddress = '0;
  logic        srd = 1'b0, swr = 1'b0, gpio_latch = 1'b0;
  logic [31:0] sdata_in = '0, gpio_in = '0;
  logic [31:0] sdata_out, gpio_in_s_insp, gpio_out;
  logic        irq;

  gpio_mulpop #(.OP_W(OP_W), .RES_W(32), .BASE(BASE)) dut (
    .clk(clk), .n_reset(n_reset), .saddress(saddress), .srd(srd), .swr(swr),
    .sdata_in(sdata_in), .sdata_out(sdata_out), .gpio_in(gpio_in),
    .gpio_latch(gpio_latch), .gpio_in_s_insp(gpio_in_s_insp),
    .gpio_out(gpio_out), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, n_irq = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: operation tracked by cycles elapsed since the start edge.
  logic [31:0] m_a1, m_a2, m_w, m_l, m_cap;
  logic [63:0] m_prod;
  logic [15:0] m_cnt;
  logic        m_busy, m_was, m_ready, m_valid, m_err, m_irq, m_lat_q;
  int          m_k;

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      m_a1 = 0; m_a2 = 0; m_w = 0; m_l = 0; m_cap = 0; m_prod = 0; m_cnt = 0;
      m_busy = 0; m_ready = 1; m_valid = 1; m_err = 0; m_irq = 0; m_lat_q = 0; m_k = 0;
    end else begin
      m_was = m_busy;
      m_irq = 0;
      if (m_busy) begin
        m_k++;
        if (m_k == OP_W + 1) begin
          m_w = m_prod[31:0];
          m_l = $countones(m_prod[31:0]);
          m_valid = (m_prod[63:32] == 0);
        end
        if (m_k == OP_W + 2) begin
          m_busy = 0; m_ready = 1; m_cnt++; m_irq = 1;
        end
      end
      if (swr && saddress == A_CTRL) begin
        if (!m_was) begin
          m_busy = 1; m_k = 0; m_prod = {32'b0, m_a1} * {32'b0, m_a2};
          m_ready = 0; m_err = 0;
        end else m_err = 1;
      end
      if (swr && saddress == A_A1) m_a1 = sdata_in & 32'h00FF_FFFF;
      if (swr && saddress == A_A2) m_a2 = sdata_in & 32'h00FF_FFFF;
      if (gpio_latch && !m_lat_q) m_cap = gpio_in;
      m_lat_q = gpio_latch;
    end
  end

  function automatic logic [31:0] mdl_read(logic [15:0] a);
    case (a)
      A_A1:    return m_a1;
      A_A2:    return m_a2;
      A_W:     return m_w;
      A_L:     return m_l;
      A_CTRL:  return {29'b0, m_err, m_ready, m_valid};
      A_STATE: return !m_busy ? 32'd0 : (m_k < OP_W) ? 32'd1 : (m_k == OP_W) ? 32'd2 : 32'd3;
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    chk("irq", {31'b0, irq}, {31'b0, m_irq});
    chk("gpio_out", gpio_out, {16'h0, m_cnt});
    chk("gpio_in_s", gpio_in_s_insp, m_cap);
    if (irq === 1'b1) n_irq++;
  end

  // Tasks are entered on a falling edge and return on the next one.
  task automatic wr(logic [15:0] a, logic [31:0] d);
    saddress = a; sdata_in = d; swr = 1'b1;
    @(negedge clk);
    swr = 1'b0;
  endtask

  task automatic rd(string name, logic [15:0] a, logic [31:0] exp);
    logic [31:0] e_m;
    e_m = mdl_read(a);
    saddress = a; srd = 1'b1;
    @(negedge clk);
    srd = 1'b0;
    chk(name, sdata_out, exp);
    chk({name, "_mdl"}, sdata_out, e_m);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    rd("rst_status", A_CTRL, 32'h3);
    rd("rst_w", A_W, 32'h0);
    rd("rst_state", A_STATE, 32'h0);
    chk("rst_gpio_out", gpio_out, 32'h0);

    // 3 x 5: state walk and latency boundary
    wr(A_A1, 32'd3); wr(A_A2, 32'd5); wr(A_CTRL, 32'h0);
    rd("t1_state_mult", A_STATE, 32'd1);
    repeat (23) @(negedge clk);
    rd("t1_state_count", A_STATE, 32'd2);
    rd("t1_status_done", A_CTRL, 32'h1);
    rd("t1_w", A_W, 32'd15);
    rd("t1_l", A_L, 32'd4);
    rd("t1_status", A_CTRL, 32'h3);
    chk("t1_gpio_out", gpio_out, 32'd1);
    chk("t1_irq_count", n_irq, 32'd1);

    // full-scale operands overflow the result width
    wr(A_A1, 32'h00FF_FFFF); wr(A_A2, 32'h00FF_FFFF); wr(A_CTRL, 32'h0);
    rd("t2_w_during", A_W, 32'd15);
    rd("t2_status_busy", A_CTRL, 32'h1);
    repeat (30) @(negedge clk);
    rd("t2_w", A_W, 32'hFE00_0001);
    rd("t2_l", A_L, 32'd8);
    rd("t2_status", A_CTRL, 32'h2);

    // zero multiplier
    wr(A_A2, 32'h0); wr(A_CTRL, 32'h0);
    repeat (30) @(negedge clk);
    rd("t3_w", A_W, 32'h0);
    rd("t3_l", A_L, 32'h0);
    rd("t3_status", A_CTRL, 32'h3);

    // second start at MULT cycle 5, A1 rewritten mid-operation
    wr(A_A1, 32'd7); wr(A_A2, 32'd9); wr(A_CTRL, 32'h0);
    repeat (4) @(negedge clk);
    wr(A_CTRL, 32'hFFFF_FFFF);
    wr(A_A1, 32'd100);
    rd("t4_status_err", A_CTRL, 32'h5);
    repeat (30) @(negedge clk);
    rd("t4_w", A_W, 32'd63);
    rd("t4_l", A_L, 32'd6);
    rd("t4_status", A_CTRL, 32'h7);
    rd("t4_a1", A_A1, 32'd100);
    chk("t4_gpio_out", gpio_out, 32'd4);
    chk("t4_irq_count", n_irq, 32'd4);

    // reset mid-operation
    wr(A_A1, 32'd3); wr(A_CTRL, 32'h0);
    repeat (5) @(negedge clk);
    #2 n_reset = 1'b0;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    rd("t5_state", A_STATE, 32'h0);
    rd("t5_status", A_CTRL, 32'h3);
    rd("t5_w", A_W, 32'h0);
    rd("t5_a1", A_A1, 32'h0);
    chk("t5_gpio_out", gpio_out, 32'h0);
    repeat (30) @(negedge clk);
    chk("t5_no_irq", n_irq, 32'd4);

    // decode holes, RO writes, masking, coincident read/write
    rd("t6_hole", BASE + 16'h4, 32'h0);
    wr(A_W, 32'hDEAD_BEEF);
    rd("t6_w_ro", A_W, 32'h0);
    wr(A_A1, 32'hFF00_0001);
    rd("t6_a1_mask", A_A1, 32'h1);
    saddress = A_A1; sdata_in = 32'h34; srd = 1'b1; swr = 1'b1;
    @(negedge clk);
    srd = 1'b0; swr = 1'b0;
    chk("t6_rdwr_old", sdata_out, 32'h1);
    rd("t6_rdwr_new", A_A1, 32'h34);

    // gpio capture only on a rising latch
    gpio_in = 32'hA5A5_A5A5; gpio_latch = 1'b1;
    repeat (2) @(negedge clk);
    chk("t7_cap", gpio_in_s_insp, 32'hA5A5_A5A5);
    gpio_in = 32'h1234_5678;
    repeat (2) @(negedge clk);
    chk("t7_hold", gpio_in_s_insp, 32'hA5A5_A5A5);
    gpio_latch = 1'b0;
    repeat (2) @(negedge clk);
    gpio_latch = 1'b1;
    repeat (2) @(negedge clk);
    chk("t7_recap", gpio_in_s_insp, 32'h1234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
